// File: rtl/dmem_axi_master.sv
// rtl/dmem_axi_master.sv - MEM-stage load/store to single-beat AXI4 master
// One request per instruction; the result is held in DONE while the pipeline is frozen.
module dmem_axi_master #(
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemEnM,
  input  logic                MemWriteM,
  input  logic [1:0]          MemSizeM,
  input  logic [31:0]         MemAddrM,
  input  logic [3:0]          MemSelM,
  input  logic [31:0]         MemWdataM,
  input  logic                ExceptSignal,
  input  logic                LongestStall,
  output logic                MemoryStall,
  output logic [31:0]         MemRdataM,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} stateT;

  stateT       state, stateNext;
  logic [31:0] addrQ;
  logic [1:0]  sizeQ;
  logic [31:0] wdataQ;
  logic [3:0]  strbQ;
  logic        awDone, wDone;
  logic        req, awHs, wHs, bothDone;
  logic        unusedInputs;

  assign unusedInputs = ^{rresp, rlast, bresp};

  assign req      = MemEnM & ~ExceptSignal;
  assign awHs     = awvalid & awready;
  assign wHs      = wvalid & wready;
  assign bothDone = (awDone | awHs) & (wDone | wHs);

  // AXI payload comes only from the latched copy so the pipeline may change its inputs.
  assign arid    = ID_WIDTH'(AXI_ID);
  assign awid    = ID_WIDTH'(AXI_ID);
  assign araddr  = addrQ;
  assign awaddr  = addrQ;
  assign arsize  = {1'b0, sizeQ};
  assign awsize  = {1'b0, sizeQ};
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wdata   = wdataQ;
  assign wstrb   = strbQ;
  assign wlast   = wvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      sizeQ     <= '0;
      wdataQ    <= '0;
      strbQ     <= '0;
      awDone    <= 1'b0;
      wDone     <= 1'b0;
      MemRdataM <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req) begin
        addrQ  <= MemAddrM;
        sizeQ  <= MemSizeM;
        wdataQ <= MemWdataM;
        strbQ  <= MemSelM;
      end
      if (state == R && rvalid) begin
        MemRdataM <= rdata;
      end
      if (state == WR) begin
        if (bothDone) begin
          awDone <= 1'b0;
          wDone  <= 1'b0;
        end else begin
          if (awHs) awDone <= 1'b1;
          if (wHs)  wDone  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    stateNext   = state;
    MemoryStall = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (state)
      IDLE: begin
        MemoryStall = req;
        if (req) stateNext = MemWriteM ? WR : AR;
      end
      AR: begin
        MemoryStall = 1'b1;
        arvalid     = 1'b1;
        if (arready) stateNext = R;
      end
      R: begin
        MemoryStall = 1'b1;
        rready      = 1'b1;
        if (rvalid) stateNext = DONE;
      end
      WR: begin
        MemoryStall = 1'b1;
        awvalid     = ~awDone;
        wvalid      = ~wDone;
        if ((awDone | awready) & (wDone | wready)) stateNext = B;
      end
      B: begin
        MemoryStall = 1'b1;
        bready      = 1'b1;
        if (bvalid) stateNext = DONE;
      end
      DONE: begin
        // Hold the result until the pipeline actually advances.
        if (!LongestStall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_axi_master.sv
// tb/tb_dmem_axi_master.sv - table-driven bench with slave model and scoreboard for dmem_axi_master
module tb_dmem_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemEnM = 1'b0, MemWriteM = 1'b0, ExceptSignal = 1'b0, LongestStall = 1'b0;
  logic [1:0]  MemSizeM = '0;
  logic [31:0] MemAddrM = '0, MemWdataM = '0;
  logic [3:0]  MemSelM = '0;
  logic        MemoryStall;
  logic [31:0] MemRdataM;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata = '0, wdata;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b1;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic        bvalid = 1'b0, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp = '0, bresp = '0;

  dmem_axi_master #(.ID_WIDTH(4), .AXI_ID(1)) dut (
    .clk(clk), .rst(rst), .MemEnM(MemEnM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .MemAddrM(MemAddrM), .MemSelM(MemSelM), .MemWdataM(MemWdataM), .ExceptSignal(ExceptSignal),
    .LongestStall(LongestStall), .MemoryStall(MemoryStall), .MemRdataM(MemRdataM),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
    .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          arDly, rDly, awDly, wDly, bDly, hold;
    logic        exceptInR;
  } vecT;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } sbT;

  sbT          expQ[$];
  vecT         vecs[7];
  int          applied = 0;
  int          miscompares = 0;
  logic [31:0] lastRdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearSlave();
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic runVec(input vecT v);
    sbT e;
    int stallCnt, expStall, arCnt, rCnt, awCnt, wCnt, bCnt, arHs, awHs, wHs, cyc;
    bit done;
    stallCnt = 0; arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
    arHs = 0; awHs = 0; wHs = 0; cyc = 0; done = 0;
    @(negedge clk);
    MemEnM = 1'b1; MemWriteM = v.isWrite; MemSizeM = v.size; MemAddrM = v.addr;
    MemSelM = v.sel; MemWdataM = v.wdata; ExceptSignal = 1'b0; LongestStall = 1'b0;
    e.isWrite = v.isWrite; e.addr = v.addr; e.size = v.size;
    e.data = v.isWrite ? v.wdata : v.rdata; e.strb = v.sel;
    expQ.push_back(e);
    if (v.isWrite) expStall = 1 + ((v.awDly > v.wDly) ? v.awDly : v.wDly) + 1 + v.bDly + 1;
    else           expStall = 1 + v.arDly + 1 + v.rDly + 1;
    while (!done && cyc < 100) begin
      if (cyc > 0) begin
        @(negedge clk);
        // The pipeline is free to change its inputs once the request is latched.
        MemEnM = 1'b0; MemWriteM = ~v.isWrite; MemSizeM = ~v.size; MemAddrM = ~v.addr;
        MemSelM = ~v.sel; MemWdataM = ~v.wdata;
      end
      #1;
      if (MemoryStall || cyc == 0) begin
        if (MemoryStall) stallCnt++;
        if (arvalid) begin
          check("ar_single", arHs, 0);
          check("araddr", araddr, expQ[0].addr);
          check("arsize", {29'd0, arsize}, {30'd0, expQ[0].size});
          check("ar_attr", {18'd0, arlen, arburst, arid}, {18'd0, 8'd0, 2'b01, 4'd1});
          arready = (arCnt >= v.arDly);
          if (arready) arHs++;
          arCnt++;
        end else arready = 1'b0;
        if (rready) begin
          if (v.exceptInR) ExceptSignal = 1'b1;
          rvalid = (rCnt >= v.rDly);
          rdata  = rvalid ? v.rdata : ~v.rdata;
          rCnt++;
        end else rvalid = 1'b0;
        if (awvalid) begin
          check("aw_single", awHs, 0);
          check("awaddr", awaddr, expQ[0].addr);
          check("awsize", {29'd0, awsize}, {30'd0, expQ[0].size});
          check("aw_attr", {18'd0, awlen, awburst, awid}, {18'd0, 8'd0, 2'b01, 4'd1});
          awready = (awCnt >= v.awDly);
          if (awready) awHs++;
          awCnt++;
        end else awready = 1'b0;
        if (wvalid) begin
          check("w_single", wHs, 0);
          check("wdata", wdata, expQ[0].data);
          check("wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, expQ[0].strb, 1'b1});
          wready = (wCnt >= v.wDly);
          if (wready) wHs++;
          wCnt++;
        end else wready = 1'b0;
        if (bready) begin
          check("b_after_aw_w", {31'd0, (awHs == 1 && wHs == 1)}, 1);
          bvalid = (bCnt >= v.bDly);
          bCnt++;
        end else bvalid = 1'b0;
        cyc++;
      end else begin
        done = 1;
      end
    end
    clearSlave();
    if (!done) begin
      applied++; miscompares++;
      $display("FAIL timeout: no completion within 100 cycles");
      void'(expQ.pop_front());
      MemEnM = 1'b0; ExceptSignal = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0; lastRdata = '0;
      return;
    end
    e = expQ.pop_front();
    if (!e.isWrite) lastRdata = e.data;
    check("stall_cycles", stallCnt, expStall);
    check("handshakes", {arHs[7:0], awHs[7:0], wHs[7:0], 8'd0},
          e.isWrite ? 32'h0001_0100 : 32'h0100_0000);
    check("rdata_done", MemRdataM, lastRdata);
    for (int h = 0; h < v.hold; h++) begin
      // A fresh request during the freeze must not start anything while in DONE.
      LongestStall = 1'b1; MemEnM = 1'b1; MemWriteM = 1'b0;
      @(negedge clk); #1;
      check("hold_stall", {29'd0, MemoryStall, arvalid, awvalid}, 0);
      check("hold_rdata", MemRdataM, lastRdata);
    end
    LongestStall = 1'b0; MemEnM = 1'b0; ExceptSignal = 1'b0;
    @(negedge clk); #1;
    check("idle_after", {29'd0, MemoryStall, arvalid, awvalid}, 0);
  endtask

  initial begin
    //              wr    addr           sz    wdata          sel     rdata         ar r aw w b hold exc
    vecs[0] = '{1'b0, 32'h8000_0010, 2'd2, 32'h0,         4'h0,   32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[1] = '{1'b0, 32'h1000_0004, 2'd2, 32'h0,         4'h0,   32'h1234_5678, 3, 2, 0, 0, 0, 0, 1'b0};
    vecs[2] = '{1'b1, 32'h2000_0008, 2'd1, 32'h0000_1234, 4'b0011, 32'h0,        0, 0, 2, 0, 1, 0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0003, 2'd0, 32'h0,         4'h0,   32'h0000_00A5, 0, 0, 0, 0, 0, 4, 1'b0};
    vecs[4] = '{1'b1, 32'h4000_0100, 2'd2, 32'hCAFE_F00D, 4'hF,   32'h0,        0, 0, 0, 3, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 32'h4000_0202, 2'd0, 32'h00AB_0000, 4'b0100, 32'h0,       1, 0, 1, 1, 2, 2, 1'b0};
    vecs[6] = '{1'b0, 32'h5000_0040, 2'd2, 32'h0,         4'h0,   32'h0BAD_CAFE, 1, 3, 0, 0, 0, 0, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valids", {26'd0, MemoryStall, arvalid, rready, awvalid, wvalid, bready}, 0);
    check("reset_rdata", MemRdataM, 32'h0);

    for (int i = 0; i < 7; i++) runVec(vecs[i]);

    // Exception gates the request entirely.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemEnM = 1'b1; ExceptSignal = 1'b1; MemWriteM = i[0]; MemAddrM = 32'h6000_0000;
      #1;
      check("except_block", {29'd0, MemoryStall, arvalid, awvalid}, 0);
    end
    @(negedge clk);
    MemEnM = 1'b0; ExceptSignal = 1'b0;
    #1;
    check("except_rdata", MemRdataM, lastRdata);

    // Reset while AR is waiting abandons the transaction.
    @(negedge clk);
    MemEnM = 1'b1; MemWriteM = 1'b0; MemAddrM = 32'h7000_0000; MemSizeM = 2'd2;
    @(negedge clk);
    MemEnM = 1'b0;
    #1;
    check("pre_rst_arvalid", {30'd0, arvalid, MemoryStall}, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_ar", {30'd0, arvalid, MemoryStall}, 0);
    check("rst_mid_rdata", MemRdataM, 32'h0);
    lastRdata = '0;

    runVec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
